// File: rtl/interconn_rxbuf.sv
// Receive-side buffer for one MVU lane: captures crossbar words into a small FIFO
// and drains them into local MVU memory through a grant-gated base/length address generator.
module interconn_rxbuf #(
    parameter int W  = 128,
    parameter int D  = 8,
    parameter int AW = 10,
    parameter int CW = 10
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   cfg_start,
    input  logic [AW-1:0]          cfg_base,
    input  logic [CW-1:0]          cfg_len,
    input  logic                   recv_en,
    input  logic [W-1:0]           recv_word,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [W-1:0]           mem_wdata,
    input  logic                   mem_gnt,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf,
    output logic [$clog2(D):0]     fill
);

    localparam int PW = $clog2(D);
    localparam int FW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    mem [D];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [AW-1:0]   addr;
    logic [CW-1:0]   acc_rem;
    logic [CW-1:0]   wr_rem;

    logic push_req;
    logic push_ok;
    logic drop;
    logic pop;

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign mem_we    = busy && (fill != '0);
    assign mem_addr  = addr;
    // Head is masked while empty so the unreset storage never leaks onto the port.
    assign mem_wdata = (fill != '0) ? mem[rd_ptr] : '0;

    assign pop      = mem_we && mem_gnt;
    assign push_req = busy && recv_en && (acc_rem != '0);
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign push_ok  = push_req && ((fill != FW'(D)) || pop);
    assign drop     = push_req && !push_ok;

    // NOTE: the word storage has no reset; only pointers and occupancy need a defined start.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= recv_word;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= ST_IDLE;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            fill    <= '0;
            addr    <= '0;
            acc_rem <= '0;
            wr_rem  <= '0;
            ovf     <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                addr   <= addr + 1'b1;
            end
            if (push_ok && !pop)
                fill <= fill + 1'b1;
            else if (!push_ok && pop)
                fill <= fill - 1'b1;

            // Dropped words still count against both budgets so the transfer terminates.
            if (push_req)
                acc_rem <= acc_rem - 1'b1;
            if (pop || drop)
                wr_rem <= wr_rem - 1'b1;
            if (drop)
                ovf <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        ovf <= 1'b0;
                        if (cfg_len != '0) begin
                            state   <= ST_RUN;
                            addr    <= cfg_base;
                            acc_rem <= cfg_len;
                            wr_rem  <= cfg_len;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (pop && (wr_rem == CW'(1)))
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interconn_rxbuf.sv
// Self-checking bench for interconn_rxbuf: a scoreboard queue holds expected
// address/data pairs and a negedge monitor pops one per completed memory write.
module tb_interconn_rxbuf;

    localparam int W  = 128;
    localparam int D  = 8;
    localparam int AW = 10;
    localparam int CW = 10;
    localparam int FW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          clr;
    logic          cfg_start;
    logic [AW-1:0] cfg_base;
    logic [CW-1:0] cfg_len;
    logic          recv_en;
    logic [W-1:0]  recv_word;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic          mem_gnt;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [FW-1:0] fill;

    typedef struct {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] exp_addr;
    int            checks   = 0;
    int            errors   = 0;
    int            wr_cnt   = 0;
    int            done_cnt = 0;

    interconn_rxbuf #(.W(W), .D(D), .AW(AW), .CW(CW)) dut (
        .clk       (clk),
        .clr       (clr),
        .cfg_start (cfg_start),
        .cfg_base  (cfg_base),
        .cfg_len   (cfg_len),
        .recv_en   (recv_en),
        .recv_word (recv_word),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: a write completes at the next rising edge when mem_we && mem_gnt.
    always @(negedge clk) begin
        if (!clr && mem_we && mem_gnt) begin
            exp_t e;
            checks++;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: addr=%h data=%h with no expected write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d) begin
                    errors++;
                    $display("FAIL write_order: got addr=%h data=%h, want addr=%h data=%h",
                             mem_addr, mem_wdata, e.a, e.d);
                end
            end
        end
        if (done)
            done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start(input logic [AW-1:0] base, input logic [CW-1:0] len);
        cfg_base  = base;
        cfg_len   = len;
        cfg_start = 1'b1;
        exp_addr  = base;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] w, input bit expect_write);
        recv_en   = 1'b1;
        recv_word = w;
        if (expect_write) begin
            exp_q.push_back('{a: exp_addr, d: w});
            exp_addr = exp_addr + 1'b1;
        end
        tick();
        recv_en = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int budget, input string name);
        int n = 0;
        while (done_cnt == prev && n < budget) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (done_cnt != prev + 1) begin
            errors++;
            $display("FAIL %s_done: done pulses=%0d, want 1", name, done_cnt - prev);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check_bit({name, "_we"}, mem_we, 1'b0);
        check_int({name, "_addr"}, int'(mem_addr), 0);
        checks++;
        if (mem_wdata !== '0) begin
            errors++;
            $display("FAIL %s_wdata: got %h, want 0", name, mem_wdata);
        end
        check_bit({name, "_busy"}, busy, 1'b0);
        check_bit({name, "_done"}, done, 1'b0);
        check_bit({name, "_ovf"}, ovf, 1'b0);
        check_int({name, "_fill"}, int'(fill), 0);
    endtask

    task automatic test_reset();
        clr       = 1'b1;
        cfg_start = 1'b0;
        cfg_base  = '0;
        cfg_len   = '0;
        recv_en   = 1'b0;
        recv_word = '0;
        mem_gnt   = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        clr = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int wr0 = wr_cnt;
        int dn0 = done_cnt;
        mem_gnt = 1'b1;
        start(10'h010, 10'd4);
        check_bit("basic_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(rnd_word(), 1'b1);
            check_bit("basic_we_each_cycle", mem_we, 1'b1);
        end
        check_int("basic_last_addr", int'(mem_addr), 'h013);
        tick();
        check_bit("basic_done_pulse", done, 1'b1);
        tick();
        check_bit("basic_done_one_cycle", done, 1'b0);
        check_bit("basic_busy_after", busy, 1'b0);
        check_bit("basic_ovf", ovf, 1'b0);
        check_int("basic_writes", wr_cnt - wr0, 4);
        check_int("basic_done_count", done_cnt - dn0, 1);
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a_hold;
        logic [W-1:0]  d_hold;
        int wr0 = wr_cnt;
        int dn0 = done_cnt;
        mem_gnt = 1'b0;
        start(10'h100, 10'd3);
        for (int i = 0; i < 3; i++)
            send(rnd_word(), 1'b1);
        repeat (2) tick();
        check_int("bp_fill", int'(fill), 3);
        check_bit("bp_we_held", mem_we, 1'b1);
        check_int("bp_addr_held", int'(mem_addr), 'h100);
        a_hold = mem_addr;
        d_hold = mem_wdata;
        tick();
        checks++;
        if (mem_addr !== a_hold || mem_wdata !== d_hold) begin
            errors++;
            $display("FAIL bp_stable: addr=%h data=%h, want addr=%h data=%h", mem_addr, mem_wdata, a_hold, d_hold);
        end
        mem_gnt = 1'b1;
        wait_done(dn0, 20, "bp");
        check_int("bp_writes", wr_cnt - wr0, 3);
    endtask

    task automatic test_overflow();
        int wr0 = wr_cnt;
        int dn0 = done_cnt;
        mem_gnt = 1'b0;
        start(10'h200, 10'd12);
        for (int i = 0; i < 12; i++) begin
            send(rnd_word(), i < D);
            if (i == D - 1)
                check_bit("ovf_before_drop", ovf, 1'b0);
            if (i == D)
                check_bit("ovf_on_ninth", ovf, 1'b1);
        end
        check_int("ovf_fill_full", int'(fill), D);
        check_bit("ovf_still_busy", busy, 1'b1);
        mem_gnt = 1'b1;
        wait_done(dn0, 30, "ovf");
        check_int("ovf_writes", wr_cnt - wr0, D);
        check_bit("ovf_sticky", ovf, 1'b1);
    endtask

    task automatic test_wrap_and_zero();
        int wr0 = wr_cnt;
        int dn0 = done_cnt;
        mem_gnt = 1'b1;
        start(10'h3FE, 10'd3);
        check_bit("wrap_ovf_cleared", ovf, 1'b0);
        for (int i = 0; i < 3; i++)
            send(rnd_word(), 1'b1);
        wait_done(dn0, 20, "wrap");
        check_int("wrap_writes", wr_cnt - wr0, 3);

        wr0 = wr_cnt;
        dn0 = done_cnt;
        start(10'h055, 10'd0);
        check_bit("zero_done", done, 1'b1);
        check_bit("zero_we", mem_we, 1'b0);
        check_bit("zero_busy", busy, 1'b0);
        tick();
        check_bit("zero_done_cleared", done, 1'b0);
        tick();
        check_int("zero_writes", wr_cnt - wr0, 0);
        check_int("zero_done_count", done_cnt - dn0, 1);
    endtask

    task automatic test_ignored();
        int wr0 = wr_cnt;
        int dn0 = done_cnt;
        mem_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(rnd_word(), 1'b0);
            check_bit("idle_recv_we", mem_we, 1'b0);
            check_int("idle_recv_fill", int'(fill), 0);
        end

        start(10'h080, 10'd4);
        for (int i = 0; i < 6; i++)
            send(rnd_word(), i < 4);
        wait_done(dn0, 20, "extra");
        check_int("extra_writes", wr_cnt - wr0, 4);
        check_bit("extra_ovf", ovf, 1'b0);

        wr0 = wr_cnt;
        dn0 = done_cnt;
        start(10'h020, 10'd4);
        send(rnd_word(), 1'b1);
        send(rnd_word(), 1'b1);
        cfg_base  = 10'h300;
        cfg_len   = 10'd1;
        cfg_start = 1'b1;
        send(rnd_word(), 1'b1);
        cfg_start = 1'b0;
        send(rnd_word(), 1'b1);
        wait_done(dn0, 20, "midstart");
        repeat (3) tick();
        check_int("midstart_writes", wr_cnt - wr0, 4);
        check_int("midstart_done_count", done_cnt - dn0, 1);
        check_bit("midstart_idle", busy, 1'b0);
    endtask

    task automatic test_reset_mid();
        int wr0 = wr_cnt;
        int dn0 = done_cnt;
        mem_gnt = 1'b1;
        start(10'h040, 10'd8);
        for (int i = 0; i < 4; i++)
            send(rnd_word(), 1'b1);
        check_int("rstmid_writes_before", wr_cnt - wr0, 3);
        #1;
        clr = 1'b1;
        #1;
        check_idle_outputs("rstmid");
        exp_q.delete();
        repeat (3) tick();
        clr = 1'b0;
        repeat (2) tick();
        check_int("rstmid_no_done", done_cnt - dn0, 0);

        wr0 = wr_cnt;
        start(10'h050, 10'd2);
        send(rnd_word(), 1'b1);
        send(rnd_word(), 1'b1);
        wait_done(dn0, 20, "rstmid_after");
        check_int("rstmid_after_writes", wr_cnt - wr0, 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_wrap_and_zero();
        test_ignored();
        test_reset_mid();
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected writes never seen, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
